// File: rtl/paralelo_serie.sv
// Parallel-to-serial transmitter: buffers 8-bit words and serializes them MSB-first,
// filling idle slots with COMMA. Optional macro PS_BC_FILTER_EN drops incoming COMMA words.
module paralelo_serie #(
  parameter int unsigned MIN_IDLE = 4,
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       word_start,
  output logic       sending_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [2:0]    MIN_IDLE_C = 3'(MIN_IDLE);

  typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    pos_q, pos_d;
  logic [2:0]    idle_cnt_q, idle_cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic          data_out_q, data_out_d;
  logic          word_start_q, word_start_d;
  logic          sending_q, sending_d;

  logic          slot_start_s;
  logic          ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    word_s;

  assign slot_start_s = (pos_q == 3'd0);
  assign ready_s      = (state_q == ST_RUN) && (count_q < DEPTH_C);
  assign accept_s     = valid_in && ready_s;
`ifdef PS_BC_FILTER_EN
  // A COMMA word completes the handshake but never reaches the buffer.
  assign push_s       = accept_s && (data_in != COMMA);
`else
  assign push_s       = accept_s;
`endif
  assign pop_s        = slot_start_s && (state_q == ST_RUN) && (count_q != '0);
  assign word_s       = pop_s ? mem_q[rd_ptr_q] : COMMA;

  // Next-state for slot counter, sync FSM, buffer bookkeeping and serializer.
  always_comb begin
    pos_d        = pos_q + 3'd1;
    idle_cnt_d   = idle_cnt_q;
    state_d      = state_q;
    wr_ptr_d     = push_s ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;
    count_d      = count_q;
    shift_d      = {shift_q[6:0], 1'b0};
    data_out_d   = shift_q[7];
    word_start_d = 1'b0;
    sending_d    = sending_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    if (slot_start_s) begin
      shift_d      = {word_s[6:0], 1'b0};
      data_out_d   = word_s[7];
      word_start_d = 1'b1;
      sending_d    = pop_s;
    end else begin
      word_start_d = 1'b0;
    end

    case (state_q)
      ST_SYNC: begin
        if (slot_start_s && (idle_cnt_q < MIN_IDLE_C)) begin
          idle_cnt_d = idle_cnt_q + 3'd1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
        // Leave SYNC only after the last bit of the MIN_IDLE-th comma.
        if ((pos_q == 3'd7) && (idle_cnt_q == MIN_IDLE_C)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_SYNC;
    endcase
  end

  // State, buffer and registered serial outputs.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SYNC;
      pos_q        <= 3'd0;
      idle_cnt_q   <= 3'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shift_q      <= 8'h00;
      data_out_q   <= 1'b0;
      word_start_q <= 1'b0;
      sending_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      idle_cnt_q   <= idle_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      word_start_q <= word_start_d;
      sending_q    <= sending_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

  assign ready_out    = ready_s;
  assign data_out     = data_out_q;
  assign word_start   = word_start_q;
  assign sending_data = sending_q;

endmodule

// File: tb/tb_paralelo_serie.sv
// Directed self-checking bench for paralelo_serie: sync burst, latency, back-pressure,
// simultaneous push/pop, mid-slot reset and COMMA input handling.
module tb_paralelo_serie;

  localparam logic [7:0] COMMA_C = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       word_start;
  logic       sending_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] src_q [$];

  paralelo_serie dut (
    .clk_8f       (clk_8f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .word_start   (word_start),
    .sending_data (sending_data)
  );

  always #5 clk_8f = ~clk_8f;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      valid_in = 1'b1;
      data_in  = src_q[0];
    end else begin
      valid_in = 1'b0;
      data_in  = 8'h00;
    end
  endtask

  // One clock edge; the source retires its head word when the handshake fired.
  task automatic tick();
    logic acc;
    acc = valid_in && ready_out;
    @(posedge clk_8f);
    #1;
    if (acc && (src_q.size() > 0)) void'(src_q.pop_front());
    drive_src();
  endtask

  // rdy holds the expected ready_out after each edge of the slot, MSB first.
  task automatic expect_slot(input string tag, input logic [7:0] word, input logic sd,
                             input logic [7:0] rdy, input int nedges);
    for (int k = 0; k < nedges; k++) begin
      tick();
      check_val({tag, "/dout"}, data_out, word[7-k]);
      check_val({tag, "/ws"}, word_start, (k == 0) ? 1 : 0);
      check_val({tag, "/sd"}, sending_data, sd);
      check_val({tag, "/rdy"}, ready_out, rdy[7-k]);
    end
  endtask

  task automatic sync_phase(input string tag);
    expect_slot({tag, "_c1"}, COMMA_C, 1'b0, 8'h00, 8);
    expect_slot({tag, "_c2"}, COMMA_C, 1'b0, 8'h00, 8);
    expect_slot({tag, "_c3"}, COMMA_C, 1'b0, 8'h00, 8);
    expect_slot({tag, "_c4"}, COMMA_C, 1'b0, 8'h01, 8);
  endtask

  initial begin
    #3;
    check_val("rst_dout", data_out, 0);
    check_val("rst_ws", word_start, 0);
    check_val("rst_sd", sending_data, 0);
    check_val("rst_rdy", ready_out, 0);
    #19 reset = 1'b1;

    sync_phase("sync1");

    // Single word: one comma slot of latency, then data.
    src_q.push_back(8'hA5);
    drive_src();
    expect_slot("a5_gap", COMMA_C, 1'b0, 8'hFF, 8);
    expect_slot("a5", 8'hA5, 1'b1, 8'hFF, 8);

    // Back-pressure with a continuously valid source.
    src_q.push_back(8'h01);
    src_q.push_back(8'h02);
    src_q.push_back(8'h03);
    src_q.push_back(8'h04);
    drive_src();
    expect_slot("bp_gap", COMMA_C, 1'b0, 8'h80, 8);
    expect_slot("bp_01", 8'h01, 1'b1, 8'h80, 8);
    expect_slot("bp_02", 8'h02, 1'b1, 8'h80, 8);
    expect_slot("bp_03", 8'h03, 1'b1, 8'hFF, 8);
    expect_slot("bp_04", 8'h04, 1'b1, 8'hFF, 8);
    expect_slot("bp_idle", COMMA_C, 1'b0, 8'hFF, 8);

    // Push on the slot-start edge that pops the only buffered word.
    src_q.push_back(8'h5A);
    drive_src();
    expect_slot("pp_gap", COMMA_C, 1'b0, 8'hFF, 8);
    src_q.push_back(8'hC3);
    drive_src();
    expect_slot("pp_5a", 8'h5A, 1'b1, 8'hFF, 8);
    expect_slot("pp_c3", 8'hC3, 1'b1, 8'hFF, 8);

    // Reset in the middle of a data word, with another word still buffered.
    src_q.push_back(8'h77);
    src_q.push_back(8'h66);
    drive_src();
    expect_slot("mr_gap", COMMA_C, 1'b0, 8'h80, 8);
    expect_slot("mr_77", 8'h77, 1'b1, 8'hFF, 5);
    #2 reset = 1'b0;
    #1;
    check_val("mr_dout", data_out, 0);
    check_val("mr_ws", word_start, 0);
    check_val("mr_sd", sending_data, 0);
    check_val("mr_rdy", ready_out, 0);
    src_q.delete();
    drive_src();
    @(posedge clk_8f);
    @(posedge clk_8f);
    #2 reset = 1'b1;
    sync_phase("sync2");
    expect_slot("mr_lost", COMMA_C, 1'b0, 8'hFF, 8);

    // COMMA offered as input data.
    src_q.push_back(8'hBC);
    src_q.push_back(8'h3C);
    drive_src();
`ifdef PS_BC_FILTER_EN
    expect_slot("bc_gap", COMMA_C, 1'b0, 8'hFF, 8);
    expect_slot("bc_3c", 8'h3C, 1'b1, 8'hFF, 8);
    expect_slot("bc_idle", COMMA_C, 1'b0, 8'hFF, 8);
`else
    expect_slot("bc_gap", COMMA_C, 1'b0, 8'h80, 8);
    expect_slot("bc_bc", 8'hBC, 1'b1, 8'hFF, 8);
    expect_slot("bc_3c", 8'h3C, 1'b1, 8'hFF, 8);
    expect_slot("bc_idle", COMMA_C, 1'b0, 8'hFF, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/paralelo_serie.md
Name: paralelo_serie

Overview:
- Transmit-side parallel-to-serial converter. It sits directly upstream of the serial-to-parallel receiver.
- Accepts 8-bit words over a valid/ready handshake into a small buffer and serializes them MSB-first on clk_8f.
- Fills every idle word slot with the comma 0xBC.
- After reset, sends a guaranteed burst of commas before any data, so the receiver can count commas and activate.

Parameters:
MIN_IDLE, 4, number of full comma words sent after reset before data is accepted (1..7)
DEPTH, 2, input buffer depth in words (power of 2, >=2)
COMMA, 8'hBC, idle/sync word

Ports:
clk_8f  input  1  bit clock; all logic on rising edge
reset  input  1  asynchronous, active-low; low clears all state
data_in  input  8  parallel word
valid_in  input  1  data_in is valid
ready_out  output  1  block can accept a word this cycle
data_out  output  1  serial bit stream, MSB first
word_start  output  1  high during the first bit (bit 7) of every word slot
sending_data  output  1  high for all 8 bits of a slot carrying buffered data (low for commas)

Behaviour:
- Reset low (async): data_out=0, word_start=0, sending_data=0, ready_out=0, pos=0, idle_cnt=0, buffer empty, state=SYNC. Any partial word is abandoned.
- Word slots: a 3-bit counter pos runs 0..7 and wraps to 0. Every rising edge with reset high drives one bit.
- At an edge with pos==0 (slot start):
  - Select the word for the slot and load the shift register.
  - data_out<=word[7], word_start<=1.
  - sending_data<=1 if data was selected, else 0.
- At edges with pos 1..7: data_out<=word[7-pos], word_start<=0. sending_data holds.
- The first edge after reset release is a slot start.
- Slot selection: the buffer head is popped only if state==RUN and the buffer count before the edge is >0. Otherwise COMMA is sent.
- FSM SYNC:
  - ready_out=0.
  - idle_cnt increments at each slot start, saturating at MIN_IDLE.
  - At the edge driving bit 0 (pos==7) of slot number MIN_IDLE, state<=RUN.
  - With MIN_IDLE=4: edges 1..32 carry 4 commas; ready_out=1 from after edge 32.
- FSM RUN:
  - Stays in RUN until reset; there is no return to SYNC.
  - Commas are sent whenever the buffer is empty at slot start.
- Handshake:
  - ready_out = (state==RUN) && (count<DEPTH), decoded from registered state.
  - A transfer occurs on an edge where valid_in && ready_out. data_in is written to the buffer tail.
  - When full, ready_out=0. Words offered while full are not accepted; the source holds them. There is no bypass.
- Simultaneous push and pop at a slot start:
  - Both occur; count is unchanged.
  - The pop uses the pre-edge head. A word pushed into an empty buffer at a slot-start edge is not sent in that slot.
- Latency: a word accepted into an empty buffer at edge t appears as bit 7 on the first slot-start edge after t (1..8 edges later).
- Ordering: strict FIFO. No words are lost or duplicated.
- Buffer pointers: log2(DEPTH) bits, wrap-around. count is log2(DEPTH)+1 bits.
- Reset mid-slot: outputs clear immediately. After release the sequence restarts at SYNC with MIN_IDLE commas.

Optional Feature:
- Macro: PS_BC_FILTER_EN.
- Defined: an accepted word equal to COMMA completes the handshake normally but is discarded, never enqueued. The stream contains 0xBC only as idle fill.
- Undefined: 0xBC input words are enqueued and sent as ordinary data, with sending_data=1.

Test Plan:
- Reset release, valid_in=0 -> edges 1..32 serialize 10111100 four times, word_start at edges 1,9,17,25; ready_out rises after edge 32; commas continue.
- After SYNC, push 0xA5 at edge 33 -> slot edges 33..40 comma; edges 41..48 data_out=1,0,1,0,0,1,0,1; sending_data=1 on 41..48.
- valid_in held high with 0x01,0x02,0x03,0x04 -> ready_out drops when 2 words are buffered; words are sent back-to-back in order with no commas between them; commas resume once the buffer is empty.
- Push at a slot-start edge while 1 word is buffered and popping -> count stays 1; the new word goes in the next slot.
- Reset pulled low at pos==4 of a data word -> data_out, ready_out, word_start go 0 immediately; after release, 4 commas precede any data and the buffered word is gone.
- Push 0xBC then 0x3C -> with PS_BC_FILTER_EN only 0x3C is sent (sending_data=1 once); without it, two data slots with sending_data=1.
